// File: rtl/filt_pkg.sv
// ---------------------------------------------------------------------------
// filt_pkg
// Shared constants, the FSM state type, the folded coefficient table and the
// modulo-NTAPS address helpers for the 31-tap symmetric low-pass FIR
// sequencer on the heart-rate signal path.
//
// Contents:
//   SAMPLE_W, COEF_W, NTAPS, ACC_W  - datapath sizing
//   NPAIRS, PTR_W, K_W              - derived counter/pointer widths
//   state_t                         - IDLE / MAC / DONE
//   C_TAB[0:15]                     - unsigned Q0.12 coefficients, c[15] is centre
//   ptr_back / ptr_fwd              - circular buffer address arithmetic
// ---------------------------------------------------------------------------
package filt_pkg;

  localparam int SAMPLE_W = 10;
  localparam int COEF_W   = 12;
  localparam int NTAPS    = 31;
  localparam int ACC_W    = 22;

  localparam int NPAIRS = (NTAPS + 1) / 2;
  localparam int PTR_W  = $clog2(NTAPS);
  localparam int K_W    = $clog2(NPAIRS);
  localparam int PW1    = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  // Only half of the symmetric impulse response is stored; entry NPAIRS-1 is
  // the centre tap and is applied to a single sample.
  localparam logic [COEF_W-1:0] C_TAB [NPAIRS] = '{
    12'd13,  12'd16,  12'd23,  12'd33,  12'd49,  12'd68,  12'd91,  12'd117,
    12'd144, 12'd172, 12'd198, 12'd222, 12'd242, 12'd258, 12'd267, 12'd271
  };

  // Address of the sample k positions older than the newest one at n.
  // A spare top bit keeps the borrow visible before wrapping back into range.
  function automatic logic [PTR_W-1:0] ptr_back(input logic [PTR_W-1:0] n,
                                                input logic [K_W-1:0]   k);
    logic [PW1-1:0] nn;
    logic [PW1-1:0] kk;
    logic [PW1-1:0] r;
    nn = {1'b0, n};
    kk = PW1'(k);
    if (nn >= kk) r = nn - kk;
    else          r = nn + PW1'(NTAPS) - kk;
    return PTR_W'(r);
  endfunction

  // Address of the partner sample for pair k: starts at the oldest entry
  // (n+1) and walks towards the centre. n+1+k never exceeds 2*NTAPS.
  function automatic logic [PTR_W-1:0] ptr_fwd(input logic [PTR_W-1:0] n,
                                               input logic [K_W-1:0]   k);
    logic [PW1-1:0] r;
    r = {1'b0, n} + PW1'(k) + PW1'(1);
    if (r >= PW1'(NTAPS)) r = r - PW1'(NTAPS);
    return PTR_W'(r);
  endfunction

endpackage

// File: rtl/filter_sequencer_if.sv
// ---------------------------------------------------------------------------
// filter_sequencer_if
// Sample-in / filtered-out bundle between the SPI slave, the filter
// sequencer and the peak/trough detector.
//
// Signals:
//   sample_valid, sample                  - new sample strobe and data
//   busy, filt_valid, filtered            - MAC activity, result strobe, result
//   primed, overrun                       - history full, sticky dropped-sample flag
// Modports:
//   master - sample source / result consumer (drives sample side)
//   slave  - the filter sequencer
// ---------------------------------------------------------------------------
interface filter_sequencer_if;
  import filt_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                busy;
  logic                filt_valid;
  logic [SAMPLE_W-1:0] filtered;
  logic                primed;
  logic                overrun;

  modport master (
    output sample_valid, sample,
    input  busy, filt_valid, filtered, primed, overrun
  );

  modport slave (
    input  sample_valid, sample,
    output busy, filt_valid, filtered, primed, overrun
  );

endinterface

// File: rtl/fir_sample_buf.sv
// ---------------------------------------------------------------------------
// fir_sample_buf
// NTAPS x SAMPLE_W circular sample history for the FIR sequencer.
// One synchronous write port, two combinational read ports (one per member
// of a symmetric coefficient pair). Cleared synchronously on reset so that
// missing history before priming reads as zero.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   we, waddr, wdata        - write port
//   raddr_a, rdata_a        - read port A (newer half of the pair)
//   raddr_b, rdata_b        - read port B (older half of the pair)
// ---------------------------------------------------------------------------
module fir_sample_buf
  import filt_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [PTR_W-1:0]    waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [PTR_W-1:0]    raddr_a,
  output logic [SAMPLE_W-1:0] rdata_a,
  input  logic [PTR_W-1:0]    raddr_b,
  output logic [SAMPLE_W-1:0] rdata_b
);

  logic [SAMPLE_W-1:0] mem [NTAPS];

  // Storage: reset wipes the whole history, otherwise one write per accepted
  // sample at the slot the controller points at.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Both taps of the current pair are read combinationally so the MAC can
  // consume them in the same cycle the addresses are generated.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/filter_sequencer.sv
// ---------------------------------------------------------------------------
// filter_sequencer
// Time-multiplexed controller for the 31-tap symmetric low-pass FIR. Each
// accepted sample is written to the circular buffer, then one multiplier is
// sequenced over 16 coefficient pairs (15 pairs plus the centre tap) and the
// scaled result is presented with a one-cycle strobe.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high
//   bus    - filter_sequencer_if.slave (sample in, filtered out, status)
//
// Build option:
//   FILT_ROUND_EN - when defined, half an LSB (2048) is added before the
//                   output slice (round-half-up); otherwise the slice truncates.
// ---------------------------------------------------------------------------
module filter_sequencer
  import filt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  filter_sequencer_if.slave    bus
);

  localparam logic [K_W-1:0]   K_LAST   = K_W'(NPAIRS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NTAPS - 1);
  localparam logic [PTR_W-1:0] FILL_MAX = PTR_W'(NTAPS);

  state_t              state;
  logic [PTR_W-1:0]    wr_ptr;
  logic [K_W-1:0]      k;
  logic [ACC_W-1:0]    acc;
  logic [PTR_W-1:0]    fill;
  logic                busy_q;
  logic                filt_valid_q;
  logic [SAMPLE_W-1:0] filtered_q;
  logic                primed_q;
  logic                overrun_q;

  logic                accept;
  logic [PTR_W-1:0]    raddr_a;
  logic [PTR_W-1:0]    raddr_b;
  logic [SAMPLE_W-1:0] rdata_a;
  logic [SAMPLE_W-1:0] rdata_b;
  logic [SAMPLE_W:0]   pair_sum;
  logic [ACC_W-1:0]    mac_term;
  logic [ACC_W-1:0]    acc_out;
  logic [SAMPLE_W-1:0] result;

  // A sample is taken whenever the multiplier is not in use; in MAC it is
  // dropped and flagged instead.
  assign accept = bus.sample_valid && (state != MAC);

  // During MAC wr_ptr still points at the newest sample, so pair k combines
  // the sample k steps back with the one k steps after the oldest.
  assign raddr_a = ptr_back(wr_ptr, k);
  assign raddr_b = ptr_fwd(wr_ptr, k);

  fir_sample_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .we      (accept),
    .waddr   (wr_ptr),
    .wdata   (bus.sample),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  // Pre-add the symmetric pair so one multiply covers two taps. The centre
  // tap (last step) has no partner and is counted once.
  assign pair_sum = {1'b0, rdata_a} + ((k == K_LAST) ? '0 : {1'b0, rdata_b});
  assign mac_term = ACC_W'(C_TAB[k]) * ACC_W'(pair_sum);

  // Output scaling: coefficients are Q0.12, so the result is acc >> 12.
  // The accumulator headroom covers the rounding offset without overflow.
`ifdef FILT_ROUND_EN
  localparam logic [ACC_W-1:0] ROUND_K = ACC_W'(1) << (COEF_W - 1);
  assign acc_out = acc + ROUND_K;
`else
  assign acc_out = acc;
`endif
  assign result = SAMPLE_W'(acc_out >> COEF_W);

  // Controller FSM. IDLE and DONE both accept a new sample; DONE also
  // publishes the finished result, so a sample arriving in DONE starts the
  // next MAC with no gap. The write pointer only moves once the MAC has
  // finished so that addressing is stable for the whole sequence. The fill
  // counter saturates at NTAPS and primed is raised on the same edge that
  // accepts the NTAPS-th sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      k            <= '0;
      acc          <= '0;
      fill         <= '0;
      busy_q       <= 1'b0;
      filt_valid_q <= 1'b0;
      filtered_q   <= '0;
      primed_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      filt_valid_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            filtered_q   <= result;
            filt_valid_q <= 1'b1;
          end
          if (accept) begin
            acc    <= '0;
            k      <= '0;
            busy_q <= 1'b1;
            state  <= MAC;
            if (fill != FILL_MAX) fill <= fill + 1'b1;
            if (fill >= FILL_MAX - 1'b1) primed_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        MAC: begin
          acc <= acc + mac_term;
          if (bus.sample_valid) overrun_q <= 1'b1;
          if (k == K_LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.filt_valid = filt_valid_q;
  assign bus.filtered   = filtered_q;
  assign bus.primed     = primed_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_filter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_filter_sequencer
// Self-checking bench for filter_sequencer. A reference model keeps the
// accepted-sample history as a queue and evaluates the full 31-tap
// convolution directly; acceptance is predicted from the one-sample-per-17-
// cycles rule. Directed scenarios (reset, DC, impulse, overrun, back-to-back,
// reset mid-MAC) are followed by a randomized phase.
// Honours FILT_ROUND_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_filter_sequencer;

  localparam int COEF [16] = '{13, 16, 23, 33, 49, 68, 91, 117,
                               144, 172, 198, 222, 242, 258, 267, 271};
`ifdef FILT_ROUND_EN
  localparam int ROUND_ADD = 2048;
  localparam int IMP16     = 68;
`else
  localparam int ROUND_ADD = 0;
  localparam int IMP16     = 67;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  int nChecks = 0;
  int nErrors = 0;

  int hist[$];
  int expVal[$];
  int expCyc[$];
  int obsVal[$];
  int obsCyc[$];
  int seen[$];
  int lastAccept = -1000;
  int nAccepted = 0;
  int expOverrun = 0;

  filter_sequencer_if bus();

  filter_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock and an edge counter used to time-stamp events.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every result strobe is logged with its cycle stamp, sampled on
  // the falling edge well away from the active edge.
  always @(negedge clk) begin
    if (bus.filt_valid === 1'b1) begin
      obsVal.push_back(int'(bus.filtered));
      obsCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Direct convolution over the last 31 accepted samples, newest first;
  // history not yet received counts as zero.
  function automatic int modelOut();
    int sum = 0;
    for (int j = 0; j < 31; j++) begin
      int cj = (j <= 15) ? COEF[j] : COEF[30 - j];
      if (j < hist.size()) sum += cj * hist[j];
    end
    sum += ROUND_ADD;
    return sum / 4096;
  endfunction

  function automatic int seenAt(input int idx);
    return (idx < seen.size()) ? seen[idx] : -1;
  endfunction

  task automatic doReset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    hist.delete();
    expVal.delete();
    expCyc.delete();
    lastAccept = -1000;
    nAccepted = 0;
    expOverrun = 0;
  endtask

  // One-cycle sample strobe. The model decides acceptance: a sample seen
  // fewer than 17 edges after the previous acceptance lands in MAC and is
  // dropped.
  task automatic applyStimulus(input logic [9:0] s);
    int e;
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample = s;
    e = cyc + 1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    if (e - lastAccept >= 17) begin
      hist.push_front(int'(s));
      if (hist.size() > 31) void'(hist.pop_back());
      nAccepted++;
      expVal.push_back(modelOut());
      expCyc.push_back(e + 17);
      lastAccept = e;
    end else begin
      expOverrun = 1;
    end
  endtask

  task automatic drainCheck(input string tag);
    int idx = 0;
    repeat (20) @(negedge clk);
    checkOutput({tag, " count"}, obsVal.size(), expVal.size());
    while (obsVal.size() > 0 && expVal.size() > 0) begin
      int ov = obsVal.pop_front();
      int oc = obsCyc.pop_front();
      int ev = expVal.pop_front();
      int ec = expCyc.pop_front();
      seen.push_back(ov);
      checkOutput($sformatf("%s value#%0d", tag, idx), ov, ev);
      checkOutput($sformatf("%s cycle#%0d", tag, idx), oc, ec);
      idx++;
    end
    obsVal.delete();
    obsCyc.delete();
    expVal.delete();
    expCyc.delete();
    checkOutput({tag, " overrun"}, int'(bus.overrun), expOverrun);
    checkOutput({tag, " primed"}, int'(bus.primed), (nAccepted >= 31) ? 1 : 0);
    checkOutput({tag, " busy idle"}, int'(bus.busy), 0);
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample = '0;

    doReset(3);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset filt_valid", int'(bus.filt_valid), 0);
    checkOutput("reset filtered", int'(bus.filtered), 0);
    checkOutput("reset primed", int'(bus.primed), 0);
    checkOutput("reset overrun", int'(bus.overrun), 0);

    seen.delete();
    for (int i = 0; i < 31; i++) begin
      applyStimulus(10'd512);
      checkOutput($sformatf("dc primed after %0d", i + 1), int'(bus.primed), (i >= 30) ? 1 : 0);
      repeat (18) @(negedge clk);
    end
    drainCheck("dc");
    checkOutput("dc 31st output", seenAt(30), 512);

    doReset(3);
    seen.delete();
    for (int i = 0; i < 32; i++) begin
      applyStimulus((i == 0) ? 10'd1023 : 10'd0);
      repeat (18) @(negedge clk);
    end
    drainCheck("impulse");
    checkOutput("impulse 1st", seenAt(0), 3);
    checkOutput("impulse 16th", seenAt(15), IMP16);
    checkOutput("impulse 31st", seenAt(30), 3);
    checkOutput("impulse 32nd", seenAt(31), 0);

    doReset(3);
    applyStimulus(10'd700);
    repeat (3) @(negedge clk);
    applyStimulus(10'd300);
    checkOutput("overrun flag", int'(bus.overrun), 1);
    drainCheck("overrun");

    doReset(3);
    applyStimulus(10'd400);
    repeat (15) @(negedge clk);
    applyStimulus(10'd900);
    drainCheck("b2b");

    doReset(3);
    applyStimulus(10'd1000);
    repeat (6) @(negedge clk);
    doReset(3);
    drainCheck("abort");
    seen.delete();
    applyStimulus(10'd1023);
    drainCheck("after abort");
    checkOutput("after abort 1st", seenAt(0), 3);

    doReset(3);
    for (int i = 0; i < 80; i++) begin
      applyStimulus(10'($urandom_range(0, 1023)));
      repeat ($urandom_range(1, 22)) @(negedge clk);
    end
    drainCheck("random");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
